ot_drain_sched: RTL and testbench
=================================

Name: ot_drain_sched

Overview:
- Sequences the draining of LANES parallel quantization output FIFOs into one AXI-Stream master for a frame of cfg_beats words.
- Lanes are visited in strict rotation (lane 0, 1, …, LANES-1, 0, …), so the output preserves the interleaved order produced by the quantization lanes.
- Collects each lane FIFO's overflow error into sticky per-lane flags, readable per frame.

Parameters:
- LANES, 4, number of output FIFOs / quantization lanes (>=2)
- DATA_BITS, 64, FIFO word and stream width
- CNT_BITS, 16, width of the frame beat counter

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  one-cycle frame start request
- cfg_beats  input  CNT_BITS  beats in the frame, sampled on accepted start
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last beat is accepted downstream
- fifo_empty_n  input  LANES  per-lane FIFO non-empty
- fifo_read  output  LANES  per-lane pop strobe, one-hot or zero, combinational
- fifo_data  input  LANES*DATA_BITS  per-lane head word; lane i = bits [i*DATA_BITS +: DATA_BITS]
- fifo_error  input  LANES  per-lane overflow pulse
- m_tdata  output  DATA_BITS  stream data
- m_tvalid  output  1  stream valid
- m_tready  input  1  stream ready
- m_tlast  output  1  marks the final beat of the frame
- err_sticky  output  LANES  sticky overflow flags

Behaviour:
- Reset values: busy=0, done=0, m_tvalid=0, m_tlast=0, m_tdata=0, err_sticky=0, fifo_read=0. Internal: lane pointer=0, remaining=0, state=IDLE.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - start with cfg_beats!=0: latch remaining=cfg_beats, set ptr=0, clear err_sticky, go to RUN; busy=1 from the next cycle.
  - start with cfg_beats==0: done=1 on the next cycle, stay in IDLE, no pops.
- start is ignored while busy.
- Pop condition (RUN only): remaining!=0 && fifo_empty_n[ptr] && (!m_tvalid || m_tready).
- On a pop, in the same cycle:
  - fifo_read[ptr]=1 (combinational).
  - Registered on that edge: m_tdata<=fifo_data[ptr], m_tvalid<=1, m_tlast<=(remaining==1), remaining<=remaining-1.
  - ptr<=(ptr==LANES-1)?0:ptr+1.
- No pop and m_tready: m_tvalid<=0, m_tlast<=0.
- No pop and !m_tready: hold m_tdata, m_tvalid and m_tlast stable (AXI rule).
- Throughput is one beat per cycle when the current lane is non-empty and tready=1. Latency from pop to m_tvalid is 1 cycle.
- Current lane empty: stall in place. Never skip to another lane, and never read any other lane.
- Pop taking remaining to 0: go to DRAIN.
- DRAIN: on m_tvalid&&m_tready, clear m_tvalid and m_tlast, pulse done=1 the next cycle, busy=0 in that same cycle, return to IDLE.
- The final beat's handshake always occurs in DRAIN.
- err_sticky[i] is set whenever fifo_error[i]=1, in any state, including busy=0. Only reset or an accepted start clears it. If start and fifo_error coincide, the set wins.
- Reset mid-frame: all outputs return to reset values the next cycle; the partial frame is abandoned. The FIFOs are not flushed by this block.
- fifo_read is gated to 0 whenever reset=1.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE, ST_RUN, ST_DRAIN (2 bits).
  - Lane-index width function, clog2(LANES).
  - Default DATA_BITS=64.
- Natural sub-module: ot_drain_outreg, the one-entry output register with valid/ready hold logic and the load/clear interface. The scheduler FSM, pointer, counter and error flags remain in ot_drain_sched.

Test Plan:
- Order: LANES=4, each FIFO preloaded with 2 words (lane i words 0xi0, 0xi1), cfg_beats=8, tready=1.
  - Output order: 0x00, 0x10, 0x20, 0x30, 0x01, 0x11, 0x21, 0x31, contiguous.
  - tlast only on 0x31; done one cycle after its handshake.
- Backpressure: same frame, tready toggled 1010….
  - All 8 beats appear in order, with no drop or duplicate.
  - m_tdata is stable while tvalid=1 and tready=0; fifo_read is 0 on stalled cycles.
- Lane stall: lane 2 empty, cfg_beats=4.
  - Beats from lanes 0 and 1 are emitted, then the block stalls; lane 3 is never read.
  - After lane 2 gets a word, beats 3 and 4 come from lanes 2 and 3; done follows.
- Zero-length frame: start with cfg_beats=0.
  - done=1 next cycle, busy stays 0, fifo_read is never asserted.
- Error flags: fifo_error[1] pulses mid-frame.
  - err_sticky=4'b0010 and stays set after done; it clears on the next accepted start.
- Reset mid-frame: assert reset after 3 beats of an 8-beat frame.
  - busy, m_tvalid and err_sticky read 0 the next cycle.
  - The next start with cfg_beats=4 reads lane 0 first.

Source files
------------

// File: rtl/ot_drain_sched_pkg.sv
// Shared definitions for the output-FIFO drain scheduler.
package ot_drain_sched_pkg;

  localparam int DEFAULT_DATA_BITS = 64;

  // Scheduler states; the encoding is fixed so debug dumps stay readable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of a lane index; never narrower than one bit.
  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/ot_drain_outreg.sv
// One-entry AXI-Stream output register. A load captures a new beat; a clear
// (downstream ready) retires the current beat; otherwise the beat is held
// stable so the stream never changes under backpressure.
module ot_drain_outreg
  import ot_drain_sched_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 load_last,
  input  logic                 clr,
  output logic                 can_load,
  output logic [DATA_BITS-1:0] tdata,
  output logic                 tvalid,
  output logic                 tlast
);

  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 last_r;

  // A new beat may enter when the slot is empty or is leaving this cycle.
  assign can_load = !valid_r || clr;

  assign tdata  = data_r;
  assign tvalid = valid_r;
  assign tlast  = last_r;

  // Output slot: load wins, then retire on ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
      last_r  <= load_last;
    end else if (clr) begin
      data_r  <= data_r;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
      last_r  <= last_r;
    end
  end

endmodule

// File: rtl/ot_drain_sched.sv
// Drains LANES quantization output FIFOs into a single AXI-Stream master in
// strict lane rotation for a frame of cfg_beats words, and keeps sticky
// per-lane overflow flags for the frame.
module ot_drain_sched
  import ot_drain_sched_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int CNT_BITS  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_BITS-1:0]        cfg_beats,
  output logic                       busy,
  output logic                       done,
  input  logic [LANES-1:0]           fifo_empty_n,
  output logic [LANES-1:0]           fifo_read,
  input  logic [LANES*DATA_BITS-1:0] fifo_data,
  input  logic [LANES-1:0]           fifo_error,
  output logic [DATA_BITS-1:0]       m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [LANES-1:0]           err_sticky
);

  localparam int            LW        = lane_bits(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t               state_r;
  logic [LW-1:0]        ptr_r;
  logic [CNT_BITS-1:0]  remaining_r;
  logic                 busy_r;
  logic                 done_r;
  logic [LANES-1:0]     err_r;

  logic [DATA_BITS-1:0] lane_data_s;
  logic                 lane_ready_s;
  logic                 can_load_s;
  logic                 pop_s;
  logic                 start_ok_s;
  logic                 last_beat_s;
  logic [LW-1:0]        ptr_next_s;
  logic [LANES-1:0]     read_s;

  // Select the head word and non-empty flag of the lane under the pointer.
  always_comb begin
    lane_data_s  = '0;
    lane_ready_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_data_s  = lane_data_s
                   | (fifo_data[i*DATA_BITS +: DATA_BITS]
                      & {DATA_BITS{ptr_r == LW'(i)}});
      lane_ready_s = lane_ready_s | (fifo_empty_n[i] & (ptr_r == LW'(i)));
    end
  end

  // Pop only the pointed lane; an empty lane stalls the rotation in place.
  assign pop_s = (state_r == ST_RUN) && (remaining_r != '0) && lane_ready_s
              && can_load_s && !reset;

  assign start_ok_s  = (state_r == ST_IDLE) && start && (cfg_beats != '0);
  assign last_beat_s = (remaining_r == CNT_BITS'(1));
  assign ptr_next_s  = (ptr_r == LAST_LANE) ? '0 : ptr_r + LW'(1);

  // Decode the one-hot pop strobe for the current lane.
  always_comb begin
    read_s = '0;
    for (int i = 0; i < LANES; i++) begin
      read_s[i] = pop_s && (ptr_r == LW'(i));
    end
  end

  assign fifo_read  = read_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err_sticky = err_r;

  ot_drain_outreg #(
    .DATA_BITS (DATA_BITS)
  ) u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (pop_s),
    .load_data (lane_data_s),
    .load_last (last_beat_s),
    .clr       (m_tready),
    .can_load  (can_load_s),
    .tdata     (m_tdata),
    .tvalid    (m_tvalid),
    .tlast     (m_tlast)
  );

  // Frame sequencer: pointer, beat counter, busy/done and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      remaining_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= '0;
    end else begin
      done_r <= 1'b0;
      // A fresh frame clears the flags, but a coincident error still lands.
      err_r  <= (start_ok_s ? '0 : err_r) | fifo_error;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (cfg_beats != '0) begin
              remaining_r <= cfg_beats;
              ptr_r       <= '0;
              busy_r      <= 1'b1;
              state_r     <= ST_RUN;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pop_s) begin
            remaining_r <= remaining_r - CNT_BITS'(1);
            ptr_r       <= ptr_next_s;
            if (last_beat_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The final beat is still in the output slot; finish on its handshake.
          if (m_tvalid && m_tready) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ot_drain_sched.sv
// Scoreboard bench for ot_drain_sched: lane FIFO models feed the DUT, the
// expected beat order is queued as words are loaded, and every stream
// handshake is popped and compared.
module tb_ot_drain_sched;

  localparam int LANES = 4;
  localparam int DB    = 64;
  localparam int CB    = 16;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          last;
  } exp_t;

  logic                clk;
  logic                reset;
  logic                start;
  logic [CB-1:0]       cfg_beats;
  logic                busy;
  logic                done;
  logic [LANES-1:0]    fifo_empty_n;
  logic [LANES-1:0]    fifo_read;
  logic [LANES*DB-1:0] fifo_data;
  logic [LANES-1:0]    fifo_error;
  logic [DB-1:0]       m_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;
  logic [LANES-1:0]    err_sticky;

  int total;
  int bad;
  int cyc;

  exp_t          exp_q[$];
  logic [DB-1:0] mem [LANES][16];
  int            wr_p [LANES];
  int            rd_p [LANES];
  int            rd_cnt [LANES];
  int            hs_count;
  int            last_hs_cyc;
  int            done_cyc;
  int            start_cyc;

  ot_drain_sched #(.LANES(LANES), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_beats    (cfg_beats),
    .busy         (busy),
    .done         (done),
    .fifo_empty_n (fifo_empty_n),
    .fifo_read    (fifo_read),
    .fifo_data    (fifo_data),
    .fifo_error   (fifo_error),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .err_sticky   (err_sticky)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int lane, input logic [DB-1:0] w);
    mem[lane][wr_p[lane] % 16] = w;
    wr_p[lane]++;
  endtask

  task automatic exp_push(input logic [DB-1:0] w, input logic last);
    exp_t e;
    e.data = w;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Two words per lane, 0xi0 then 0xi1, expected in rotation order.
  task automatic load_frame2();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < LANES; i++) begin
        push_word(i, DB'(i * 16 + k));
        exp_push(DB'(i * 16 + k), (k == 1) && (i == LANES - 1));
      end
    end
  endtask

  task automatic do_start(input logic [CB-1:0] beats);
    start     = 1'b1;
    cfg_beats = beats;
    step();
    start     = 1'b0;
    cfg_beats = '0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    bit got;
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (done) begin
        got      = 1'b1;
        done_cyc = cyc;
      end else begin
        step();
        if (toggle) m_tready = ~m_tready;
      end
    end
    check_eq({tag, "_done_seen"}, got, 1'b1);
  endtask

  // Checks made at the negedge where done is high.
  task automatic frame_end(input string tag, input int hs_base, input int beats);
    check_eq({tag, "_beats"}, hs_count - hs_base, beats);
    check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
    check_eq({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
    check_eq({tag, "_busy_off"}, busy, 1'b0);
  endtask

  // Lane FIFO models: pop what the DUT strobed, then present the new heads.
  task automatic fifo_proc();
    logic [LANES-1:0] snap;
    forever begin
      @(negedge clk);
      snap = fifo_read;
      @(posedge clk);
      #1;
      for (int i = 0; i < LANES; i++) begin
        if (snap[i] && (rd_p[i] != wr_p[i])) rd_p[i]++;
        fifo_empty_n[i]         = (rd_p[i] != wr_p[i]);
        fifo_data[i*DB +: DB]   = (rd_p[i] != wr_p[i]) ? mem[i][rd_p[i] % 16] : '0;
      end
    end
  endtask

  // Stream monitor: scoreboard compare, AXI hold rule and pop-strobe sanity.
  task automatic mon_proc();
    exp_t          e;
    bit            prev_stall;
    logic [DB-1:0] prev_data;
    logic          prev_last;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check_eq("rd_in_reset", fifo_read, 0);
        prev_stall = 1'b0;
      end else begin
        check_eq("rd_onehot0", $onehot0(fifo_read), 1'b1);
        for (int i = 0; i < LANES; i++) if (fifo_read[i]) rd_cnt[i]++;
        if (prev_stall) begin
          check_eq("hold_valid", m_tvalid, 1'b1);
          check_eq("hold_data", m_tdata, prev_data);
          check_eq("hold_last", m_tlast, prev_last);
        end
        if (m_tvalid && !m_tready) check_eq("rd_when_stalled", fifo_read, 0);
        if (m_tvalid && m_tready) begin
          check_eq("sb_avail", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("beat_data", m_tdata, e.data);
            check_eq("beat_last", m_tlast, e.last);
          end
          hs_count++;
          if (m_tlast) last_hs_cyc = cyc;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  endtask

  initial begin
    int hb;
    int rd_sum;
    bit seen;
    total = 0; bad = 0; cyc = 0;
    hs_count = 0; last_hs_cyc = 0; done_cyc = 0; start_cyc = 0;
    reset = 1'b1; start = 1'b0; cfg_beats = '0;
    fifo_error = '0; m_tready = 1'b1;
    fifo_empty_n = '0; fifo_data = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_p[i] = 0; rd_p[i] = 0; rd_cnt[i] = 0;
    end
    fork
      fifo_proc();
      mon_proc();
    join_none

    // Reset values.
    step(); step(); step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_tvalid", m_tvalid, 1'b0);
    check_eq("rst_tlast", m_tlast, 1'b0);
    check_eq("rst_tdata", m_tdata, 0);
    check_eq("rst_err", err_sticky, 0);
    check_eq("rst_read", fifo_read, 0);
    reset = 1'b0;
    step();

    // Order: 8 contiguous beats in rotation order, tlast only on 0x31.
    load_frame2();
    step();
    hb = hs_count;
    do_start(CB'(8));
    check_eq("ord_busy", busy, 1'b1);
    wait_done("ord", 60, 1'b0);
    frame_end("ord", hb, 8);
    check_eq("ord_span", done_cyc - start_cyc, 9);
    step();
    check_eq("ord_done_pulse", done, 1'b0);

    // Backpressure: tready toggles, data held, no drop or duplicate.
    load_frame2();
    step();
    hb = hs_count;
    do_start(CB'(8));
    wait_done("bp", 100, 1'b1);
    frame_end("bp", hb, 8);
    m_tready = 1'b1;
    step();

    // Lane stall: lane 2 empty stalls the rotation; lane 3 is not read.
    push_word(0, 64'h00); push_word(1, 64'h10); push_word(3, 64'h30);
    exp_push(64'h00, 1'b0); exp_push(64'h10, 1'b0);
    exp_push(64'h20, 1'b0); exp_push(64'h30, 1'b1);
    step();
    hb = hs_count;
    for (int i = 0; i < LANES; i++) rd_cnt[i] = 0;
    do_start(CB'(4));
    for (int n = 0; n < 10; n++) step();
    check_eq("stall_beats", hs_count - hb, 2);
    check_eq("stall_rd2", rd_cnt[2], 0);
    check_eq("stall_rd3", rd_cnt[3], 0);
    check_eq("stall_busy", busy, 1'b1);
    push_word(2, 64'h20);
    wait_done("stall", 40, 1'b0);
    frame_end("stall", hb, 4);
    check_eq("stall_rd2_end", rd_cnt[2], 1);
    check_eq("stall_rd3_end", rd_cnt[3], 1);
    step();

    // Zero-length frame.
    for (int i = 0; i < LANES; i++) rd_cnt[i] = 0;
    do_start(CB'(0));
    check_eq("zero_done", done, 1'b1);
    check_eq("zero_busy", busy, 1'b0);
    step();
    check_eq("zero_done_off", done, 1'b0);
    check_eq("zero_busy2", busy, 1'b0);
    rd_sum = 0;
    for (int i = 0; i < LANES; i++) rd_sum += rd_cnt[i];
    check_eq("zero_no_reads", rd_sum, 0);

    // Error flags: sticky across done, cleared by the next start.
    load_frame2();
    step();
    hb = hs_count;
    do_start(CB'(8));
    step(); step();
    fifo_error = 4'b0010;
    step();
    fifo_error = 4'b0000;
    wait_done("err", 60, 1'b0);
    frame_end("err", hb, 8);
    check_eq("err_after_done", err_sticky, 4'b0010);
    step(); step(); step();
    check_eq("err_held", err_sticky, 4'b0010);
    for (int i = 0; i < LANES; i++) begin
      push_word(i, DB'(8'hB0 + i));
      exp_push(DB'(8'hB0 + i), i == LANES - 1);
    end
    step();
    hb = hs_count;
    do_start(CB'(4));
    check_eq("err_cleared", err_sticky, 4'b0000);
    wait_done("err2", 40, 1'b0);
    frame_end("err2", hb, 4);
    step();

    // Reset mid-frame after 3 beats.
    load_frame2();
    step();
    hb = hs_count;
    do_start(CB'(8));
    fifo_error = 4'b1000;
    step();
    fifo_error = 4'b0000;
    for (int n = 0; n < 30 && (hs_count - hb) < 3; n++) step();
    check_eq("mid_hs3", (hs_count - hb) >= 3, 1'b1);
    check_eq("mid_err_set", err_sticky, 4'b1000);
    reset = 1'b1;
    step();
    check_eq("mid_busy", busy, 1'b0);
    check_eq("mid_tvalid", m_tvalid, 1'b0);
    check_eq("mid_err", err_sticky, 0);
    check_eq("mid_tlast", m_tlast, 1'b0);
    #2;
    exp_q.delete();
    for (int i = 0; i < LANES; i++) rd_p[i] = wr_p[i];
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      push_word(i, DB'(8'hC0 + i));
      exp_push(DB'(8'hC0 + i), i == LANES - 1);
    end
    step(); step();
    hb = hs_count;
    do_start(CB'(4));
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (fifo_read != 0) begin
        seen = 1'b1;
        check_eq("post_rst_first_lane", fifo_read, 4'b0001);
      end else begin
        step();
      end
    end
    check_eq("post_rst_read_seen", seen, 1'b1);
    wait_done("post", 40, 1'b0);
    frame_end("post", hb, 4);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
